// File: rtl/als_controlador_sequenciador_pkg.sv
// Shared constants for the SAP-1 controller-sequencer: opcodes, CON bit map,
// per-T-state control words and the one-hot T-state encoding.
package als_controlador_sequenciador_pkg;

    localparam int unsigned CW_WIDTH = 12;
    localparam int unsigned N_T      = 6;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // CON bit positions, bit 11 = Cp down to bit 0 = nLo
    localparam int unsigned CON_CP  = 11;
    localparam int unsigned CON_EP  = 10;
    localparam int unsigned CON_NLM = 9;
    localparam int unsigned CON_NCE = 8;
    localparam int unsigned CON_NLI = 7;
    localparam int unsigned CON_NEI = 6;
    localparam int unsigned CON_NLA = 5;
    localparam int unsigned CON_EA  = 4;
    localparam int unsigned CON_SU  = 3;
    localparam int unsigned CON_EU  = 2;
    localparam int unsigned CON_NLB = 1;
    localparam int unsigned CON_NLO = 0;

    localparam logic [CW_WIDTH-1:0] CW_IDLE     = 12'h3E3;
    localparam logic [CW_WIDTH-1:0] CW_FETCH_T1 = 12'h5E3;
    localparam logic [CW_WIDTH-1:0] CW_FETCH_T2 = 12'hBE3;
    localparam logic [CW_WIDTH-1:0] CW_FETCH_T3 = 12'h263;
    localparam logic [CW_WIDTH-1:0] CW_MEM_T4   = 12'h1A3;
    localparam logic [CW_WIDTH-1:0] CW_LDA_T5   = 12'h2C3;
    localparam logic [CW_WIDTH-1:0] CW_ALU_T5   = 12'h2E1;
    localparam logic [CW_WIDTH-1:0] CW_ADD_T6   = 12'h3C7;
    localparam logic [CW_WIDTH-1:0] CW_SUB_T6   = 12'h3CF;
    localparam logic [CW_WIDTH-1:0] CW_OUT_T4   = 12'h3F2;

    typedef enum logic [N_T-1:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    function automatic logic is_one_hot(input logic [N_T-1:0] v);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < N_T; i++) begin
            ones += int'(v[i]);
        end
        return ones == 1;
    endfunction

endpackage

// File: rtl/als_controlador_sequenciador_anel.sv
// One-hot ring counter with enable and async clear; advances on the falling clock edge.
module als_contador_anel
    import als_controlador_sequenciador_pkg::*;
#(
    parameter int unsigned WIDTH = N_T
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            q <= WIDTH'(1);
        end else if (en) begin
            // Any corrupted (non-one-hot) pattern restarts the ring at T1
            if (is_one_hot(q)) begin
                q <= {q[WIDTH-2:0], q[WIDTH-1]};
            end else begin
                q <= WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/als_controlador_sequenciador.sv
// SAP-1 controller-sequencer: ring counter, halt latch, instruction counter and
// the combinational control-word decode matrix.
module als_controlador_sequenciador
    import als_controlador_sequenciador_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    input  logic [3:0]          opcode,
    output logic [CW_WIDTH-1:0] con,
    output logic [N_T-1:0]      t_state,
    output logic                hlt,
    output logic [7:0]          instr_cnt
);

    logic [N_T-1:0] ring;
    logic           hlt_q;
    logic [7:0]     cnt_q;
    logic [CW_WIDTH-1:0] cw;

    als_contador_anel #(.WIDTH(N_T)) u_anel (
        .clk (clk),
        .clr (clr),
        .en  (~hlt_q),
        .q   (ring)
    );

    // HLT latches on the edge that ends T4, so the ring freezes at T5
    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            hlt_q <= 1'b0;
        end else if (!hlt_q && ring == T4 && opcode == OP_HLT) begin
            hlt_q <= 1'b1;
        end
    end

    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (!hlt_q && ring == T6) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    always_comb begin
        cw = CW_IDLE;
        if (!clr && !hlt_q) begin
            case (ring)
                T1: cw = CW_FETCH_T1;
                T2: cw = CW_FETCH_T2;
                T3: cw = CW_FETCH_T3;
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: cw = CW_MEM_T4;
                        OP_OUT:                 cw = CW_OUT_T4;
                        default:                cw = CW_IDLE;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA:         cw = CW_LDA_T5;
                        OP_ADD, OP_SUB: cw = CW_ALU_T5;
                        default:        cw = CW_IDLE;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD:  cw = CW_ADD_T6;
                        OP_SUB:  cw = CW_SUB_T6;
                        default: cw = CW_IDLE;
                    endcase
                end
                default: cw = CW_IDLE;
            endcase
        end
    end

    assign con       = cw;
    assign t_state   = ring;
    assign hlt       = hlt_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_als_controlador_sequenciador.sv
// Self-checking bench: directed scenarios plus random opcode streams against a
// step-index reference model of the SAP-1 instruction cycle.
module tb_als_controlador_sequenciador;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  opcode;
    logic [11:0] con;
    logic [5:0]  t_state;
    logic        hlt;
    logic [7:0]  instr_cnt;

    int   checks = 0;
    int   errors = 0;

    // Reference model: step 0..5 = T1..T6
    int       m_step;
    bit       m_halted;
    bit [7:0] m_cnt;

    als_controlador_sequenciador dut (
        .clk       (clk),
        .clr       (clr),
        .opcode    (opcode),
        .con       (con),
        .t_state   (t_state),
        .hlt       (hlt),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model_con(int s, logic [3:0] op, bit h, logic c);
        if (c || h) return 12'h3E3;
        case (s)
            0: return 12'h5E3;
            1: return 12'hBE3;
            2: return 12'h263;
            3: begin
                if (op == 4'h0 || op == 4'h1 || op == 4'h2) return 12'h1A3;
                if (op == 4'hE) return 12'h3F2;
                return 12'h3E3;
            end
            4: begin
                if (op == 4'h0) return 12'h2C3;
                if (op == 4'h1 || op == 4'h2) return 12'h2E1;
                return 12'h3E3;
            end
            default: begin
                if (op == 4'h1) return 12'h3C7;
                if (op == 4'h2) return 12'h3CF;
                return 12'h3E3;
            end
        endcase
    endfunction

    task automatic check(input string tag);
        logic [11:0] e_con;
        logic [5:0]  e_t;
        e_con = model_con(m_step, opcode, m_halted, clr);
        e_t   = 6'(1 << m_step);
        checks++;
        assert (con === e_con) else begin
            errors++;
            $error("FAIL %s con observed=%h expected=%h", tag, con, e_con);
        end
        checks++;
        assert (t_state === e_t) else begin
            errors++;
            $error("FAIL %s t_state observed=%b expected=%b", tag, t_state, e_t);
        end
        checks++;
        assert (hlt === m_halted) else begin
            errors++;
            $error("FAIL %s hlt observed=%b expected=%b", tag, hlt, m_halted);
        end
        checks++;
        assert (instr_cnt === m_cnt) else begin
            errors++;
            $error("FAIL %s instr_cnt observed=%0d expected=%0d", tag, instr_cnt, m_cnt);
        end
    endtask

    // Advance one falling edge, update the model with the opcode seen at that edge
    task automatic tick(input string tag);
        @(negedge clk);
        if (!clr && !m_halted) begin
            if (m_step == 3 && opcode == 4'hF) m_halted = 1'b1;
            if (m_step == 5) m_cnt = m_cnt + 8'd1;
            m_step = (m_step + 1) % 6;
        end
        #2;
        check(tag);
    endtask

    task automatic set_op(input logic [3:0] op, input string tag);
        opcode = op;
        #1;
        check(tag);
    endtask

    // Assert clr between clock edges, check immediately, release after a posedge
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        clr      = 1'b1;
        m_step   = 0;
        m_halted = 1'b0;
        m_cnt    = '0;
        #1;
        check(tag);
        @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        check(tag);
    endtask

    initial begin
        int hold;
        clr      = 1'b1;
        opcode   = 4'h0;
        m_step   = 0;
        m_halted = 1'b0;
        m_cnt    = '0;
        #3;
        check("por");
        do_reset("reset");

        // LDA, one full instruction
        set_op(4'h0, "lda_t1");
        for (int i = 0; i < 6; i++) tick("lda");

        // SUB then ADD
        set_op(4'h2, "sub_t1");
        for (int i = 0; i < 6; i++) tick("sub");
        set_op(4'h1, "add_t1");
        for (int i = 0; i < 6; i++) tick("add");

        // Undefined opcode behaves as NOP
        set_op(4'h5, "nop_t1");
        for (int i = 0; i < 6; i++) tick("nop");

        // HLT: reach T4 with LDA on the bus, then switch to HLT
        set_op(4'h0, "hlt_pre");
        for (int i = 0; i < 3; i++) tick("hlt_fetch");
        set_op(4'hF, "hlt_t4");
        tick("hlt_edge");
        for (int i = 0; i < 20; i++) begin
            if (i == 10) set_op(4'h1, "hlt_opchg");
            tick("halted");
        end
        do_reset("hlt_clr");
        tick("post_hlt");

        // Opcode change during T2 is invisible until T4; clr in T5 restarts
        do_reset("t2_reset");
        set_op(4'h0, "t2_t1");
        tick("t2_enter");
        set_op(4'hE, "t2_chg");
        for (int i = 0; i < 2; i++) tick("t2_run");
        tick("out_t5");
        do_reset("t5_clr");
        tick("after_t5_clr");

        // instr_cnt wrap after 256 NOP instructions
        do_reset("wrap_reset");
        set_op(4'h5, "wrap_op");
        for (int i = 0; i < 256 * 6; i++) tick("wrap");

        // Random opcode streams, including occasional HLT
        do_reset("rand_reset");
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 6))
                    0: set_op(4'h0, "rand_op");
                    1: set_op(4'h1, "rand_op");
                    2: set_op(4'h2, "rand_op");
                    3: set_op(4'hE, "rand_op");
                    4: set_op(4'hF, "rand_op");
                    default: set_op(4'($urandom_range(0, 15)), "rand_op");
                endcase
            end
            tick("rand");
            if (m_halted) begin
                hold++;
                if (hold > 4) begin
                    do_reset("rand_clr");
                    hold = 0;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
